// File: rtl/conv_engine_arbiter.sv
// Round-robin arbiter and job sequencer sharing one 5x5/3x3 convolution engine
// between two clients: feed IFM/weights, drain, collect NUM_OUT results, release.
module conv_engine_arbiter #(
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 36,
    parameter int IN_LEN    = 25,
    parameter int W_LEN     = 9,
    parameter int NUM_OUT   = 9,
    parameter int DRAIN_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] src_ifm0,
    input  logic [DATA_W-1:0] src_wgt0,
    input  logic [DATA_W-1:0] src_ifm1,
    input  logic [DATA_W-1:0] src_wgt1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              src_rd,
    output logic              eng_in_valid,
    output logic              eng_weight_valid,
    output logic [DATA_W-1:0] eng_ifm,
    output logic [DATA_W-1:0] eng_weight,
    input  logic              eng_out_valid,
    input  logic [OUT_W-1:0]  eng_ofm,
    output logic              res_valid,
    output logic [OUT_W-1:0]  res_data,
    output logic              res_id,
    output logic              done,
    output logic              done_id,
    output logic              err
);

    localparam int BEAT_W = $clog2(IN_LEN + 1);
    localparam int CNT_W  = $clog2(NUM_OUT + 1);
    localparam int DRN_W  = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, GAP} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
    logic [DRN_W-1:0]    drain_q, drain_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d, src_rd_q, src_rd_d;
    logic                in_valid_q, in_valid_d, wv_q, wv_d;
    logic [DATA_W-1:0]   ifm_q, ifm_d, wgt_q, wgt_d;
    logic                res_valid_q, res_valid_d, res_id_q, res_id_d;
    logic [OUT_W-1:0]    res_data_q, res_data_d;
    logic                done_q, done_d, done_id_q, done_id_d, err_q, err_d;
    logic                accept;
    logic                finish;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        res_cnt_d   = res_cnt_q;
        drain_d     = drain_q;
        owner_d     = owner_q;
        last_d      = last_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        src_rd_d    = src_rd_q;
        in_valid_d  = in_valid_q;
        wv_d        = 1'b0;
        ifm_d       = ifm_q;
        wgt_d       = wgt_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        err_d       = 1'b0;
        finish      = 1'b0;

        // Results are only owned by a job while it feeds or drains; anything else is dropped.
        accept = ((state_q == FEED) || (state_q == DRAIN)) && eng_out_valid &&
                 (res_cnt_q < CNT_W'(NUM_OUT));
        if (accept) begin
            res_valid_d = 1'b1;
            res_data_d  = eng_ofm;
            res_id_d    = owner_q;
            res_cnt_d   = res_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d   = (req0 && req1) ? ~last_q : req1;
                    gnt0_d    = ~owner_d;
                    gnt1_d    = owner_d;
                    src_rd_d  = 1'b1;
                    beat_d    = '0;
                    res_cnt_d = '0;
                    drain_d   = '0;
                    state_d   = FEED;
                end
            end
            FEED: begin
                in_valid_d = 1'b1;
                ifm_d      = owner_q ? src_ifm1 : src_ifm0;
                if (beat_q < BEAT_W'(W_LEN)) begin
                    wv_d  = 1'b1;
                    wgt_d = owner_q ? src_wgt1 : src_wgt0;
                end
                if (beat_q == BEAT_W'(IN_LEN - 1)) begin
                    state_d  = DRAIN;
                    src_rd_d = 1'b0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DRAIN: begin
                // Zero padding keeps the engine's internal beat count advancing.
                in_valid_d = 1'b1;
                ifm_d      = '0;
                if (res_cnt_d == CNT_W'(NUM_OUT)) begin
                    finish = 1'b1;
                    done_d = 1'b1;
                end else if (drain_q == DRN_W'(DRAIN_MAX - 1)) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
                if (finish) begin
                    state_d    = GAP;
                    in_valid_d = 1'b0;
                    gnt0_d     = 1'b0;
                    gnt1_d     = 1'b0;
                    done_id_d  = owner_q;
                end
            end
            GAP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            res_cnt_q   <= '0;
            drain_q     <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            src_rd_q    <= 1'b0;
            in_valid_q  <= 1'b0;
            wv_q        <= 1'b0;
            ifm_q       <= '0;
            wgt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            res_cnt_q   <= res_cnt_d;
            drain_q     <= drain_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            src_rd_q    <= src_rd_d;
            in_valid_q  <= in_valid_d;
            wv_q        <= wv_d;
            ifm_q       <= ifm_d;
            wgt_q       <= wgt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            err_q       <= err_d;
        end
    end

    assign gnt0             = gnt0_q;
    assign gnt1             = gnt1_q;
    assign src_rd           = src_rd_q;
    assign eng_in_valid     = in_valid_q;
    assign eng_weight_valid = wv_q;
    assign eng_ifm          = ifm_q;
    assign eng_weight       = wgt_q;
    assign res_valid        = res_valid_q;
    assign res_data         = res_data_q;
    assign res_id           = res_id_q;
    assign done             = done_q;
    assign done_id          = done_id_q;
    assign err              = err_q;

endmodule

// File: tb/tb_conv_engine_arbiter.sv
// Bench for conv_engine_arbiter: client buffers, a stub 5x5/3x3 engine, a job-level
// reference model compared every cycle, and directed literal checks.
module tb_conv_engine_arbiter;
    localparam int DATA_W = 16, OUT_W = 36, IN_LEN = 25, W_LEN = 9, NUM_OUT = 9, DRAIN_MAX = 16;

    logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [DATA_W-1:0] src_ifm0, src_wgt0, src_ifm1, src_wgt1;
    logic gnt0, gnt1, src_rd, eng_in_valid, eng_weight_valid;
    logic [DATA_W-1:0] eng_ifm, eng_weight;
    logic eng_out_valid = 1'b0;
    logic [OUT_W-1:0] eng_ofm = '0;
    logic res_valid, res_id, done, done_id, err;
    logic [OUT_W-1:0] res_data;

    conv_engine_arbiter #(.DATA_W(DATA_W), .OUT_W(OUT_W), .IN_LEN(IN_LEN), .W_LEN(W_LEN),
                          .NUM_OUT(NUM_OUT), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .src_ifm0(src_ifm0), .src_wgt0(src_wgt0), .src_ifm1(src_ifm1), .src_wgt1(src_wgt1),
        .gnt0(gnt0), .gnt1(gnt1), .src_rd(src_rd), .eng_in_valid(eng_in_valid),
        .eng_weight_valid(eng_weight_valid), .eng_ifm(eng_ifm), .eng_weight(eng_weight),
        .eng_out_valid(eng_out_valid), .eng_ofm(eng_ofm), .res_valid(res_valid),
        .res_data(res_data), .res_id(res_id), .done(done), .done_id(done_id), .err(err));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Client buffers: word index advances on each src_rd beat of the owning client.
    logic [DATA_W-1:0] ifm_mem [2][IN_LEN];
    logic [DATA_W-1:0] wgt_mem [2][W_LEN];
    int rd0 = 0, rd1 = 0;
    always @(posedge clk) begin
        if (!rst_n || !gnt0) rd0 <= 0; else if (src_rd) rd0 <= rd0 + 1;
        if (!rst_n || !gnt1) rd1 <= 0; else if (src_rd) rd1 <= rd1 + 1;
    end
    always_comb begin
        src_ifm0 = (rd0 < IN_LEN) ? ifm_mem[0][rd0] : 16'hDEAD;
        src_ifm1 = (rd1 < IN_LEN) ? ifm_mem[1][rd1] : 16'hDEAD;
        src_wgt0 = (rd0 < W_LEN) ? wgt_mem[0][rd0] : 16'hBEEF;
        src_wgt1 = (rd1 < W_LEN) ? wgt_mem[1][rd1] : 16'hBEEF;
    end

    // Stub engine: counts in_valid beats, emits stub_nres valid-window results after beat IN_LEN-1.
    int st_ifm [IN_LEN];
    int st_w [W_LEN];
    int stub_k = 0, stub_nres = 9;
    function automatic logic [OUT_W-1:0] conv_at(input int j);
        longint s = 0;
        int jj = j % 9;
        int r = jj / 3, c = jj % 3;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                s += longint'(st_ifm[(r + i) * 5 + c + k]) * longint'(st_w[i * 3 + k]);
        return OUT_W'(s);
    endfunction
    always @(posedge clk) begin
        if (!eng_in_valid) begin
            stub_k <= 0;
            eng_out_valid <= 1'b0;
        end else begin
            if (stub_k < IN_LEN) st_ifm[stub_k] <= int'(eng_ifm);
            if (eng_weight_valid && stub_k < W_LEN) st_w[stub_k] <= int'(eng_weight);
            eng_out_valid <= (stub_k >= IN_LEN) && (stub_k < IN_LEN + stub_nres);
            if (stub_k >= IN_LEN) eng_ofm <= conv_at(stub_k - IN_LEN);
            stub_k <= stub_k + 1;
        end
    end

    // Reference model: a job is described by its owner and the cycle offset since grant.
    logic e_gnt0 = 0, e_gnt1 = 0, e_src_rd = 0, e_in_valid = 0, e_wv = 0;
    logic [DATA_W-1:0] e_ifm = '0, e_wgt = '0;
    logic e_res_valid = 0, e_res_id = 0, e_done = 0, e_done_id = 0, e_err = 0;
    logic [OUT_W-1:0] e_res_data = '0;
    bit m_busy = 0, m_gap = 0;
    int m_owner = 0, m_last = 1, m_t = 0, m_res = 0;
    initial forever begin
        @(posedge clk);
        e_done = 0; e_err = 0; e_res_valid = 0; e_wv = 0;
        if (!rst_n) begin
            e_gnt0 = 0; e_gnt1 = 0; e_src_rd = 0; e_in_valid = 0; e_ifm = '0; e_wgt = '0;
            e_res_data = '0; e_res_id = 0; e_done_id = 0;
            m_busy = 0; m_gap = 0; m_last = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (!m_busy) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
                m_busy = 1; m_t = 0; m_res = 0;
                e_gnt0 = (m_owner == 0); e_gnt1 = (m_owner == 1); e_src_rd = 1;
            end
        end else begin
            if (eng_out_valid && m_res < NUM_OUT) begin
                e_res_valid = 1; e_res_data = eng_ofm; e_res_id = m_owner[0]; m_res++;
            end
            if (m_t < IN_LEN) begin
                e_in_valid = 1;
                e_ifm = ifm_mem[m_owner][m_t];
                if (m_t < W_LEN) begin e_wv = 1; e_wgt = wgt_mem[m_owner][m_t]; end
                e_src_rd = (m_t < IN_LEN - 1);
            end else begin
                e_ifm = '0;
                if (m_res == NUM_OUT || (m_t - IN_LEN) == DRAIN_MAX - 1) begin
                    e_done = (m_res == NUM_OUT); e_err = !e_done; e_done_id = m_owner[0];
                    e_gnt0 = 0; e_gnt1 = 0; e_in_valid = 0;
                    m_last = m_owner; m_busy = 0; m_gap = 1;
                end else begin
                    e_in_valid = 1;
                end
            end
            m_t++;
        end
    end

    bit mdl_on = 0;
    initial forever begin
        @(negedge clk);
        if (mdl_on) begin
            chk("gnt0", 64'(gnt0), 64'(e_gnt0));
            chk("gnt1", 64'(gnt1), 64'(e_gnt1));
            chk("src_rd", 64'(src_rd), 64'(e_src_rd));
            chk("eng_in_valid", 64'(eng_in_valid), 64'(e_in_valid));
            chk("eng_weight_valid", 64'(eng_weight_valid), 64'(e_wv));
            chk("eng_ifm", 64'(eng_ifm), 64'(e_ifm));
            chk("eng_weight", 64'(eng_weight), 64'(e_wgt));
            chk("res_valid", 64'(res_valid), 64'(e_res_valid));
            chk("res_data", 64'(res_data), 64'(e_res_data));
            chk("res_id", 64'(res_id), 64'(e_res_id));
            chk("done", 64'(done), 64'(e_done));
            chk("done_id", 64'(done_id), 64'(e_done_id));
            chk("err", 64'(err), 64'(e_err));
            chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'(0));
            chk("src_rd_needs_gnt", 64'(src_rd & ~(gnt0 | gnt1)), 64'(0));
        end
    end

    // Event logs for the directed checks.
    logic [OUT_W-1:0] res_q [$];
    logic rid_q [$];
    int done_ids [$];
    int err_n = 0, err_cyc = 0, drain_cyc = 0, wv_tot = 0, wv_early = 0, iv_n = 0;
    logic src_rd_prev = 0;
    initial forever begin
        @(negedge clk);
        if (res_valid) begin res_q.push_back(res_data); rid_q.push_back(res_id); end
        if (done) done_ids.push_back(int'(done_id));
        if (err) begin err_n++; err_cyc = cyc; end
        if (src_rd_prev && !src_rd && (gnt0 | gnt1)) drain_cyc = cyc;
        src_rd_prev = src_rd;
        if (eng_weight_valid) wv_tot++;
        if (eng_in_valid) begin
            if (eng_weight_valid && iv_n < W_LEN) wv_early++;
            iv_n++;
        end else iv_n = 0;
    end

    int exp_a [9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    int exp_b [9] = '{14, 16, 18, 24, 26, 28, 34, 36, 38};

    task automatic clear_logs();
        res_q.delete(); rid_q.delete(); done_ids.delete();
        err_n = 0; wv_tot = 0; wv_early = 0;
    endtask

    task automatic wait_end(input string name);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done || err) begin seen = 1; break; end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no done/err within 300 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic check_res(input string name, input int base, input int n, input int id, input bit use_b);
        for (int i = 0; i < n; i++) begin
            if (base + i >= res_q.size()) begin
                chk({name, " missing results"}, 64'(res_q.size()), 64'(base + n));
                break;
            end
            chk($sformatf("%s data%0d", name, i), 64'(res_q[base + i]), 64'(use_b ? exp_b[i] : exp_a[i]));
            chk($sformatf("%s id%0d", name, i), 64'(rid_q[base + i]), 64'(id));
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " gnt0"}, 64'(gnt0), 0);
        chk({name, " gnt1"}, 64'(gnt1), 0);
        chk({name, " src_rd"}, 64'(src_rd), 0);
        chk({name, " in_valid"}, 64'(eng_in_valid), 0);
        chk({name, " wv"}, 64'(eng_weight_valid), 0);
        chk({name, " eng_ifm"}, 64'(eng_ifm), 0);
        chk({name, " eng_weight"}, 64'(eng_weight), 0);
        chk({name, " res_valid"}, 64'(res_valid), 0);
        chk({name, " res_data"}, 64'(res_data), 0);
        chk({name, " done"}, 64'(done), 0);
        chk({name, " err"}, 64'(err), 0);
    endtask

    task automatic pulse_req(input int id);
        @(negedge clk);
        if (id == 0) req0 = 1; else req1 = 1;
        @(negedge clk);
        req0 = 0; req1 = 0;
    endtask

    initial begin
        for (int i = 0; i < IN_LEN; i++) begin
            ifm_mem[0][i] = DATA_W'(i + 1);
            ifm_mem[1][i] = DATA_W'(2 * (i + 1));
        end
        for (int i = 0; i < W_LEN; i++) begin
            wgt_mem[0][i] = 1;
            wgt_mem[1][i] = (i == 4) ? 1 : 0;
        end
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mdl_on = 1;
        chk_zero("reset");
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Single job, client 0: latency, weight window, results.
        clear_logs();
        req0 = 1;
        @(negedge clk);
        chk("t1 gnt0 one cycle after req", 64'(gnt0), 1);
        chk("t1 src_rd one cycle after req", 64'(src_rd), 1);
        chk("t1 in_valid not yet", 64'(eng_in_valid), 0);
        req0 = 0;
        @(negedge clk);
        chk("t1 in_valid one cycle after src_rd", 64'(eng_in_valid), 1);
        wait_end("t1");
        chk("t1 weight_valid total", 64'(wv_tot), 9);
        chk("t1 weight_valid first beats", 64'(wv_early), 9);
        chk("t1 result count", 64'(res_q.size()), 9);
        check_res("t1", 0, 9, 0, 0);
        chk("t1 done count", 64'(done_ids.size()), 1);
        chk("t1 done_id", 64'(done_ids.size() > 0 ? done_ids[0] : -1), 0);
        chk("t1 err count", 64'(err_n), 0);

        // Both requests held from reset for four jobs; engine emits one surplus result per job.
        @(negedge clk); rst_n = 0;
        repeat (2) @(negedge clk); rst_n = 1;
        clear_logs();
        stub_nres = 10;
        req0 = 1; req1 = 1;
        for (int j = 0; j < 4; j++) wait_end($sformatf("rr job%0d", j));
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
        chk("rr done count", 64'(done_ids.size()), 4);
        for (int j = 0; j < 4 && j < done_ids.size(); j++)
            chk($sformatf("rr order job%0d", j), 64'(done_ids[j]), 64'(j % 2));
        chk("rr result count", 64'(res_q.size()), 36);
        for (int j = 0; j < 4; j++)
            check_res($sformatf("rr job%0d", j), 9 * j, 9, j % 2, (j % 2) == 1);
        stub_nres = 9;

        // Drain timeout: only five results, err DRAIN_MAX cycles after drain entry.
        clear_logs();
        stub_nres = 5;
        pulse_req(0);
        wait_end("timeout");
        chk("to err count", 64'(err_n), 1);
        chk("to done count", 64'(done_ids.size()), 0);
        chk("to result count", 64'(res_q.size()), 5);
        check_res("to", 0, 5, 0, 0);
        chk("to err delay", 64'(err_cyc - drain_cyc), 64'(DRAIN_MAX));
        stub_nres = 9;
        clear_logs();
        pulse_req(0);
        wait_end("after timeout");
        chk("at done count", 64'(done_ids.size()), 1);
        chk("at err count", 64'(err_n), 0);
        check_res("at", 0, 9, 0, 0);

        // Reset at FEED beat 10 aborts silently; a following client 1 job is intact.
        clear_logs();
        @(negedge clk); req0 = 1;
        @(negedge clk); req0 = 0;
        repeat (10) @(negedge clk);
        chk("mr in feed", 64'(gnt0 & src_rd), 1);
        rst_n = 0;
        @(negedge clk);
        chk_zero("mid reset");
        rst_n = 1;
        repeat (40) @(negedge clk);
        chk("mr no done", 64'(done_ids.size()), 0);
        chk("mr no err", 64'(err_n), 0);
        clear_logs();
        pulse_req(1);
        wait_end("mr client1");
        chk("mr result count", 64'(res_q.size()), 9);
        check_res("mr", 0, 9, 1, 1);
        chk("mr done_id", 64'(done_ids.size() > 0 ? done_ids[0] : -1), 1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_engine_arbiter.md
Name: conv_engine_arbiter

Overview:
Round-robin arbiter and job sequencer that shares one 5x5-IFM / 3x3-weight convolution engine between two client buffers.
- On grant, it streams the client's IFM and weight words into the engine.
- It holds the engine's valid high through the drain phase.
- It returns the first NUM_OUT results tagged with the owner ID, then releases the engine.
- It sits between the client-side buffers and the convolution datapath.

Parameters:
DATA_W, 16, IFM/weight word width
OUT_W, 36, engine result width
IN_LEN, 25, IFM words per job
W_LEN, 9, weight words per job (sent on the first W_LEN feed beats; W_LEN <= IN_LEN)
NUM_OUT, 9, results collected per job
DRAIN_MAX, 16, maximum DRAIN cycles before timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req0  in  1  client 0 job request (level)
req1  in  1  client 1 job request (level)
src_ifm0  in  DATA_W  client 0 IFM word, valid while src_rd&gnt0
src_wgt0  in  DATA_W  client 0 weight word
src_ifm1  in  DATA_W  client 1 IFM word
src_wgt1  in  DATA_W  client 1 weight word
gnt0  out  1  client 0 owns engine
gnt1  out  1  client 1 owns engine
src_rd  out  1  read strobe to granted client; data sampled this cycle
eng_in_valid  out  1  to engine in_valid
eng_weight_valid  out  1  to engine weight_valid
eng_ifm  out  DATA_W  to engine IFM input
eng_weight  out  DATA_W  to engine weight input
eng_out_valid  in  1  engine result strobe
eng_ofm  in  OUT_W  engine result
res_valid  out  1  result to clients
res_data  out  OUT_W  result value
res_id  out  1  owning client of res_data
done  out  1  one-cycle job-complete pulse
done_id  out  1  client ID for done/err
err  out  1  one-cycle drain-timeout pulse

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - Reset (rst_n=0 at a clk edge) forces state IDLE, all counters 0, and the RR pointer to favour client 0.
  - Every output resets to 0.
  - Reset mid-job aborts the job silently: no done, no err.
- State machine: IDLE, FEED, DRAIN, GAP.
- IDLE:
  - If any req is high, grant per round-robin.
  - If both are high, the client not granted last wins; first after reset is client 0.
  - Next cycle: state FEED, gnt_x=1, src_rd=1.
- FEED (IN_LEN cycles):
  - src_rd=1 every cycle.
  - The selected src_ifm is registered into eng_ifm with eng_in_valid=1 the following cycle, so the engine sees data one cycle after src_rd.
  - On feed beats 0..W_LEN-1, src_wgt is registered into eng_weight with eng_weight_valid=1. Otherwise eng_weight_valid=0 and eng_weight holds its value.
  - After beat IN_LEN-1 the state goes to DRAIN and src_rd goes to 0.
- DRAIN:
  - eng_in_valid stays 1 with eng_ifm=0, and eng_weight_valid=0, so the engine's internal count advances.
  - Exit to GAP when the result count reaches NUM_OUT. done=1 and done_id=owner in the first GAP cycle.
  - Timeout: if DRAIN lasts DRAIN_MAX cycles without NUM_OUT results, exit to GAP with err=1 instead of done.
- GAP (1 cycle):
  - eng_in_valid=0 (resets the engine counter) and gnt_x=0.
  - The RR pointer is updated to the owner.
  - Next state is IDLE. A new grant can appear in the cycle after IDLE is entered, so the minimum inter-job gap is 2 cycles.
- Result path:
  - Each eng_out_valid seen during FEED or DRAIN while the result count < NUM_OUT is registered as res_valid=1, res_data=eng_ofm, res_id=owner (1-cycle latency). Extras are ignored.
  - res_data is held at its last value when res_valid=0.
- Request handling:
  - req deassert during a job is ignored: the job completes.
  - A req held high after done is re-arbitrated normally.
- Exclusivity: gnt0 and gnt1 are never both 1. src_rd is 1 only while a gnt is 1.

Test Plan:
- Single job, basic results: req0 pulse, IFM 1..25, weights all 1 → exactly 9 res_valid, res_id=0, res_data = 63,72,81,108,117,126,153,162,171; then one done with done_id=0.
- Single job, timing: same job as above → gnt0 and src_rd rise 1 cycle after req0; eng_in_valid first high 1 cycle later; eng_weight_valid high on exactly the first 9 engine cycles.
- Simultaneous requests: req0=req1=1 out of reset → client 0 served first, then client 1 with no src_rd overlap; grants never overlap; results carry the correct res_id.
- Fairness: req0 and req1 held high for 4 jobs → grant order 0,1,0,1; done_id matches each job.
- Drain timeout: stub engine emits only 5 eng_out_valid → 5 results, then err=1 exactly DRAIN_MAX cycles after DRAIN entry; done stays 0; the next job completes normally.
- Reset mid-job: rst_n low at FEED beat 10 → next cycle all outputs 0, state IDLE; a subsequent req1 job returns the correct 9 results with res_id=1.
